// File: rtl/exc_irq_ctrl_if.sv
// Bus between the exception/interrupt controller and the core datapath.
// The mask_we/mask_wdata signals exist only when IRQ_MASK_EN is defined.
interface exc_irq_ctrl_if #(
    parameter int NIRQ = 4,
    parameter int ESW  = 4
);
    logic [NIRQ-1:0] irq;
    logic            sync_exc;
    logic [ESW-1:0]  sync_code;
    logic            eret;
    logic            exc_ack;
    logic            exc;
    logic [ESW-1:0]  estatus;
    logic [NIRQ-1:0] irq_ack;
    logic            in_handler;
    logic            dbl_fault;
`ifdef IRQ_MASK_EN
    logic            mask_we;
    logic [NIRQ-1:0] mask_wdata;
`endif

    // Datapath / device side
    modport master (
        output irq, sync_exc, sync_code, eret, exc_ack,
`ifdef IRQ_MASK_EN
        output mask_we, mask_wdata,
`endif
        input  exc, estatus, irq_ack, in_handler, dbl_fault
    );

    // Controller side
    modport slave (
        input  irq, sync_exc, sync_code, eret, exc_ack,
`ifdef IRQ_MASK_EN
        input  mask_we, mask_wdata,
`endif
        output exc, estatus, irq_ack, in_handler, dbl_fault
    );
endinterface

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: latches IRQs and one sync exception, prioritises,
// holds Exc until ExcAck, tracks handler residency until ERET. Optional macro: IRQ_MASK_EN.
module exc_irq_ctrl #(
    parameter int NIRQ = 4,
    parameter int ESW  = 4
) (
    input  logic              clk,
    input  logic              reset,
    exc_irq_ctrl_if.slave     bus
);
    localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

    state_t          state_q;
    logic            exc_q;
    logic [ESW-1:0]  estatus_q;
    logic [NIRQ-1:0] irq_ack_q;
    logic            in_handler_q;
    logic            dbl_fault_q;
    logic            sel_sync_q;
    logic [IW-1:0]   sel_idx_q;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] elig;
    logic            any_elig;
    logic [IW-1:0]   win_idx;
    logic [ESW-1:0]  irq_code;

`ifdef IRQ_MASK_EN
    logic [NIRQ-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask_q <= '1;
        else        mask_q <= mask_d;
    end

    assign elig = pend_q & mask_q;
`else
    assign elig = pend_q;
`endif

    // New requests win over the acknowledge clear in the same cycle
    always_comb begin
        pend_d = (pend_q & ~irq_ack_q) | bus.irq;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    // Lowest-index eligible channel wins
    always_comb begin
        win_idx  = '0;
        any_elig = 1'b0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win_idx  = IW'(k);
                any_elig = 1'b1;
            end
        end
        irq_code = (ESW'(1) << (ESW - 1)) | ESW'(win_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            exc_q        <= 1'b0;
            estatus_q    <= '0;
            irq_ack_q    <= '0;
            in_handler_q <= 1'b0;
            dbl_fault_q  <= 1'b0;
            sel_sync_q   <= 1'b0;
            sel_idx_q    <= '0;
        end else begin
            irq_ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.sync_exc) begin
                        state_q    <= REQ;
                        exc_q      <= 1'b1;
                        estatus_q  <= bus.sync_code;
                        sel_sync_q <= 1'b1;
                    end else if (any_elig) begin
                        state_q    <= REQ;
                        exc_q      <= 1'b1;
                        estatus_q  <= irq_code;
                        sel_sync_q <= 1'b0;
                        sel_idx_q  <= win_idx;
                    end
                end
                REQ: begin
                    if (bus.exc_ack) begin
                        state_q      <= HANDLER;
                        exc_q        <= 1'b0;
                        in_handler_q <= 1'b1;
                        if (!sel_sync_q) irq_ack_q <= NIRQ'(1) << sel_idx_q;
                    end
                end
                HANDLER: begin
                    if (bus.eret) begin
                        state_q      <= IDLE;
                        in_handler_q <= 1'b0;
                    end
                    if (bus.sync_exc) dbl_fault_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.exc        = exc_q;
    assign bus.estatus    = estatus_q;
    assign bus.irq_ack    = irq_ack_q;
    assign bus.in_handler = in_handler_q;
    assign bus.dbl_fault  = dbl_fault_q;
endmodule
